// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit: evaluates SLICE bits per clock, LSB slice first,
// and publishes result/zero only when the whole word is complete.
//
// state  | meaning
// S_IDLE | waiting for start; result/zero hold the last completed value
// S_RUN  | busy; one slice of the working result is written per clock
// S_DONE | one-cycle done pulse; start here is accepted back-to-back
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, work, work_nxt;
  logic [2:0]       op_q;
  logic [SLICE-1:0] sa, sb, sr;
  logic             accept, last;
  int               base;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign last = (state == S_RUN) && (idx == LAST);

  // One shared SLICE-wide gate block, steered by the slice index.
  always_comb begin
    base = int'(idx) * SLICE;
    sa   = a_q[base +: SLICE];
    sb   = b_q[base +: SLICE];
    case (op_q)
      3'b000:  sr = sa & sb;
      3'b001:  sr = sa | sb;
      3'b010:  sr = sa ^ sb;
      3'b011:  sr = ~(sa | sb);
      3'b100:  sr = ~(sa & sb);
      3'b101:  sr = ~sa;
      3'b110:  sr = ~(sa ^ sb);
      default: sr = sa;
    endcase
    work_nxt = work;
    work_nxt[base +: SLICE] = sr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx    <= '0;
      work   <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      idx  <= '0;
      work <= '0;
    end else if (state == S_RUN) begin
      work <= work_nxt;
      idx  <= last ? '0 : idx + 1'b1;
      // Only the completed word reaches the port; partial slices stay internal.
      if (last) begin
        result <= work_nxt;
        zero   <= (work_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_mc.sv
// Bench for logic_unit_mc: a 4-slice instance and a single-slice instance,
// with expected results queued at stimulus time and compared at done.
module tb_logic_unit_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [2:0]  op, op2;
  logic [31:0] a, b, a2, b2;
  logic        busy, done, zero, busy2, done2, zero2;
  logic [31:0] result, result2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  logic_unit_mc #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  logic_unit_mc #(.WIDTH(32), .SLICE(32)) dut1 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .zero(zero2)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x ^ y;
      3'b011:  return ~(x | y);
      3'b100:  return ~(x & y);
      3'b101:  return ~x;
      3'b110:  return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    op = '0; a = '0; b = '0; op2 = '0; a2 = '0; b2 = '0;
    step; step;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
    n_checks++; if (zero2 !== 1'b1 || busy2 !== 1'b0 || result2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_n1 got busy=%b zero=%b result=%h", busy2, zero2, result2);
    end
    reset = 1'b0;
    step;
    last_res = 32'h0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
    int cycles, busy_cnt;
    logic [31:0] e;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    step;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    cycles = 0; busy_cnt = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busy_cnt++;
      n_checks++;
      if (result !== last_res) begin n_fail++; $display("FAIL %s_hold got %h want %h", name, result, last_res); end
      step;
      cycles++;
    end
    n_checks++; if (cycles != 4) begin n_fail++; $display("FAIL %s_latency got %0d want 4", name, cycles); end
    n_checks++; if (busy_cnt != 4) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 4", name, busy_cnt); end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL %s_scoreboard got empty want entry", name);
    end else begin
      e = exp_q.pop_front();
      n_checks++; if (result !== e) begin n_fail++; $display("FAIL %s_result got %h want %h", name, result, e); end
      n_checks++; if (zero !== (e == 32'h0)) begin n_fail++; $display("FAIL %s_zero got %b want %b", name, zero, (e == 32'h0)); end
      last_res = e;
    end
    step;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
    n_checks++; if (result !== last_res) begin n_fail++; $display("FAIL %s_after got %h want %h", name, result, last_res); end
  endtask

  task automatic test_basic;
    run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    run_op(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "xor_zero");
    run_op(3'b011, 32'h0, 32'h0, "nor");
    for (int i = 0; i < 8; i++) run_op(3'(i), $urandom, $urandom, "op_sweep");
  endtask

  task automatic test_back_to_back;
    int cycles, gap;
    logic [31:0] e;
    start = 1'b1; op = 3'b001; a = 32'h0000_00FF; b = 32'hFF00_0000;
    exp_q.push_back(model(3'b001, 32'h0000_00FF, 32'hFF00_0000));
    step;
    op = 3'b101; a = 32'hFFFF_0000; b = $urandom;
    exp_q.push_back(model(3'b101, 32'hFFFF_0000, 32'h0));
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin step; cycles++; end
    n_checks++; if (cycles != 4) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 4", cycles); end
    e = exp_q.pop_front();
    n_checks++; if (result !== e) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", result, e); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy got %b want 0", busy); end
    step;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got busy=%b want 1", busy); end
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin step; gap++; end
    n_checks++; if (gap != 5) begin n_fail++; $display("FAIL b2b_gap got %0d want 5", gap); end
    e = exp_q.pop_front();
    n_checks++; if (result !== e) begin n_fail++; $display("FAIL b2b_second_result got %h want %h", result, e); end
    last_res = e;
    step;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_start_ignored;
    int cnt0, cycles;
    logic [31:0] e;
    cnt0 = done_cnt;
    start = 1'b1; op = 3'b000; a = 32'h1234_5678; b = 32'hFFFF_0000;
    exp_q.push_back(model(3'b000, 32'h1234_5678, 32'hFFFF_0000));
    step;
    start = 1'b0;
    step;
    start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step;
    start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin step; cycles++; end
    e = exp_q.pop_front();
    n_checks++; if (result !== e) begin n_fail++; $display("FAIL ignored_result got %h want %h", result, e); end
    last_res = e;
    repeat (6) step;
    n_checks++; if (done_cnt - cnt0 != 1) begin n_fail++; $display("FAIL ignored_done_count got %0d want 1", done_cnt - cnt0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int cnt0;
    cnt0 = done_cnt;
    start = 1'b1; op = 3'b110; a = $urandom; b = $urandom;
    step;
    start = 1'b0;
    step; step;
    reset = 1'b1; start = 1'b1;
    step;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL abort_result got %h want 0", result); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL abort_zero got %b want 1", zero); end
    reset = 1'b0; start = 1'b0;
    last_res = 32'h0;
    repeat (6) step;
    n_checks++; if (done_cnt != cnt0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt - cnt0); end
  endtask

  task automatic test_single_slice;
    logic [31:0] e;
    start2 = 1'b1; op2 = 3'b000; a2 = 32'hF0F0_1234; b2 = 32'h0FF0_FFFF;
    exp_q.push_back(model(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF));
    step;
    start2 = 1'b0; a2 = $urandom;
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL n1_busy got %b want 1", busy2); end
    step;
    n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL n1_done got %b want 1", done2); end
    e = exp_q.pop_front();
    n_checks++; if (result2 !== e || zero2 !== 1'b0) begin n_fail++; $display("FAIL n1_result got %h/%b want %h/0", result2, zero2, e); end
    step;
    n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL n1_done_pulse got %b want 0", done2); end
    start2 = 1'b1; op2 = 3'b011; a2 = 32'h0; b2 = 32'h0;
    step;
    start2 = 1'b0; reset = 1'b1;
    step;
    n_checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || result2 !== 32'h0 || zero2 !== 1'b1) begin
      n_fail++; $display("FAIL n1_abort got busy=%b done=%b result=%h zero=%b", busy2, done2, result2, zero2);
    end
    reset = 1'b0;
    step;
    n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL n1_abort_no_done got %b want 0", done2); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid_run;
    test_single_slice;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
